// File: rtl/uart_tx_gen2_if.sv
// Bundles the UART transmitter's enqueue port, frame configuration and line/status outputs.
// master drives words and config; slave is the transmitter.
interface uart_tx_gen2_if #(
  parameter int WORD_SIZE  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_SIZE-1:0] DATA_BUS;
  logic                 DATA_VALID;
  logic                 DATA_READY;
  logic [1:0]           PARITY_MODE;
  logic                 TWO_STOP;
  logic                 SERIAL_OUT;
  logic                 BUSY;
  logic                 TX_DONE;
  logic [CNT_W-1:0]     FIFO_COUNT;

  modport master (
    output DATA_BUS, DATA_VALID, PARITY_MODE, TWO_STOP,
    input  DATA_READY, SERIAL_OUT, BUSY, TX_DONE, FIFO_COUNT
  );

  modport slave (
    input  DATA_BUS, DATA_VALID, PARITY_MODE, TWO_STOP,
    output DATA_READY, SERIAL_OUT, BUSY, TX_DONE, FIFO_COUNT
  );
endinterface

// File: rtl/uart_tx_gen2.sv
// FIFO-fed UART transmitter: start, LSB-first data, optional parity, 1/2 stop bits.
// First start bit one cycle after the word is accepted; DATA_READY drops when the FIFO is full.
module uart_tx_gen2 #(
  parameter int WORD_SIZE    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic          CLOCK,
  input  logic          RESET,
  uart_tx_gen2_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BC_W  = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(WORD_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_en_q, par_en_d;
  logic                 two_stop_q, two_stop_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;
  logic                 tx_done_q, tx_done_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];

  logic                 ready;
  logic                 push;
  logic                 pop;
  logic                 load;
  logic                 bit_end;
  logic [WORD_SIZE-1:0] head;

  assign ready   = count_q < CNT_W'(FIFO_DEPTH);
  assign push    = bus.DATA_VALID && ready;
  assign bit_end = bit_cnt_q == BC_W'(CLKS_PER_BIT - 1);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + BC_W'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    serial_d   = serial_q;
    busy_d     = busy_q;
    tx_done_d  = 1'b0;
    load       = 1'b0;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        load      = count_q != '0;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == IDX_W'(WORD_SIZE - 1)) begin
            bit_idx_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
            serial_d  = par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            shift_d   = shift_q >> 1;
            serial_d  = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
          bit_idx_d = '0;
          serial_d  = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          // bit_idx counts stop bits already sent within this state
          if (two_stop_q && bit_idx_q == '0) begin
            bit_idx_d = IDX_W'(1);
          end else begin
            tx_done_d = 1'b1;
            bit_idx_d = '0;
            if (count_q != '0) begin
              load = 1'b1;
            end else begin
              state_d  = S_IDLE;
              busy_d   = 1'b0;
              serial_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
        bit_idx_d = '0;
        serial_d  = 1'b1;
        busy_d    = 1'b0;
      end
    endcase

    // Frame start: pop head word and freeze its config for the whole frame.
    if (load) begin
      pop        = 1'b1;
      state_d    = S_START;
      bit_cnt_d  = '0;
      bit_idx_d  = '0;
      shift_d    = head;
      par_bit_d  = (^head) ^ (bus.PARITY_MODE == 2'b10);
      par_en_d   = (bus.PARITY_MODE == 2'b01) || (bus.PARITY_MODE == 2'b10);
      two_stop_d = bus.TWO_STOP;
      serial_d   = 1'b0;
      busy_d     = 1'b1;
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      serial_q   <= serial_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= bus.DATA_BUS;
      end
    end
  end

  assign bus.DATA_READY = ready;
  assign bus.SERIAL_OUT = serial_q;
  assign bus.BUSY       = busy_q;
  assign bus.TX_DONE    = tx_done_q;
  assign bus.FIFO_COUNT = count_q;
endmodule
